fpu_sqrt_sequencer: RTL and testbench

- Request front-end that sits directly upstream of the single-precision sqrt FPU and also collects its results.
- Buffers tagged operands in a small FIFO and issues them one at a time to the iterative FPU using its start/busy/done protocol.
- Holds the FPU operand stable for the whole operation, captures the result on done, and presents it downstream with valid/ready backpressure.
- Also produces per-result and sticky exception flags.

---
 rtl/fpu_sqrt_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_fpu_sqrt_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sqrt_sequencer.sv
// Request front-end for the iterative single-precision sqrt FPU: buffers tagged
// operands, issues them one at a time, and returns results with valid/ready and exception flags.
module fpu_sqrt_sequencer #(
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_operand,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic [2:0]               out_flags,
    output logic [2:0]               sticky_flags,
    input  logic                     flags_clear,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     fpu_start,
    output logic [31:0]              fpu_a,
    input  logic                     fpu_busy,
    input  logic                     fpu_done,
    input  logic [31:0]              fpu_result
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = TAG_WIDTH + 32;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // {invalid, nan_in, denorm_flushed}; -0 counts as zero, so it is not invalid.
    function automatic logic [2:0] operand_flags(input logic [31:0] op);
        logic [7:0]  exp_s;
        logic [22:0] frac_s;
        logic        frac_nz_s;
        logic        zero_s;
        logic        nan_s;
        logic        snan_s;
        logic        denorm_s;
        logic        invalid_s;
        exp_s     = op[30:23];
        frac_s    = op[22:0];
        frac_nz_s = (frac_s != 23'd0);
        zero_s    = (exp_s == 8'd0) && !frac_nz_s;
        nan_s     = (exp_s == 8'hFF) && frac_nz_s;
        snan_s    = nan_s && !frac_s[22];
        denorm_s  = (exp_s == 8'd0) && frac_nz_s;
        invalid_s = (op[31] && !zero_s && !nan_s) || snan_s;
        return {invalid_s, nan_s, denorm_s};
    endfunction

    logic [ENTRY_W-1:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [CNT_W-1:0]     count_next_s;
    logic                 in_ready_r;
    state_t               state_r;
    logic                 fpu_start_r;
    logic [31:0]          fpu_a_r;
    logic [TAG_WIDTH-1:0] tag_r;
    logic [2:0]           flags_r;
    logic                 out_valid_r;
    logic [31:0]          out_result_r;
    logic [TAG_WIDTH-1:0] out_tag_r;
    logic [2:0]           out_flags_r;
    logic [2:0]           sticky_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 capture_s;
    logic [ENTRY_W-1:0]   head_s;

    assign push_s    = in_valid && in_ready_r;
    assign pop_s     = (state_r == ST_IDLE) && (count_r != {CNT_W{1'b0}}) && !fpu_busy;
    assign capture_s = (state_r == ST_WAIT) && fpu_done;
    assign head_s    = mem_r[rd_ptr_r];

    // Post-update occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Operand storage; contents are don't-care until written, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_tag, in_operand};
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s != FULL_COUNT);
        end
    end

    // Issue/capture sequencer plus result and sticky flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            fpu_start_r  <= 1'b0;
            fpu_a_r      <= 32'd0;
            tag_r        <= {TAG_WIDTH{1'b0}};
            flags_r      <= 3'b000;
            out_valid_r  <= 1'b0;
            out_result_r <= 32'd0;
            out_tag_r    <= {TAG_WIDTH{1'b0}};
            out_flags_r  <= 3'b000;
            sticky_r     <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        fpu_a_r     <= head_s[31:0];
                        tag_r       <= head_s[ENTRY_W-1:32];
                        flags_r     <= operand_flags(head_s[31:0]);
                        fpu_start_r <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    fpu_start_r <= 1'b0;
                    state_r     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fpu_done) begin
                        out_result_r <= fpu_result;
                        out_tag_r    <= tag_r;
                        out_flags_r  <= flags_r;
                        out_valid_r  <= 1'b1;
                        state_r      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    fpu_start_r <= 1'b0;
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase

            // Clear takes effect before a coincident capture is accumulated.
            if (flags_clear) begin
                sticky_r <= capture_s ? flags_r : 3'b000;
            end else if (capture_s) begin
                sticky_r <= sticky_r | flags_r;
            end
        end
    end

    assign in_ready     = in_ready_r;
    assign pending      = count_r;
    assign fpu_start    = fpu_start_r;
    assign fpu_a        = fpu_a_r;
    assign out_valid    = out_valid_r;
    assign out_result   = out_result_r;
    assign out_tag      = out_tag_r;
    assign out_flags    = out_flags_r;
    assign sticky_flags = sticky_r;

endmodule

// File: tb/tb_fpu_sqrt_sequencer.sv
// Self-checking bench for fpu_sqrt_sequencer: behavioural FPU model, result
// scoreboard, and directed plus randomized scenarios.
`timescale 1ns/1ps
module tb_fpu_sqrt_sequencer;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_operand;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_result;
    logic [TW-1:0] out_tag;
    logic [2:0]    out_flags;
    logic [2:0]    sticky_flags;
    logic          flags_clear;
    logic [2:0]    pending;
    logic          fpu_start;
    logic [31:0]   fpu_a;
    logic          fpu_busy;
    logic          fpu_done;
    logic [31:0]   fpu_result;

    logic model_busy, model_done, hold_busy, stray_done;
    assign fpu_busy = model_busy | hold_busy;
    assign fpu_done = model_done | stray_done;

    always #5 clk = ~clk;

    fpu_sqrt_sequencer #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_operand(in_operand), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .out_flags(out_flags), .sticky_flags(sticky_flags), .flags_clear(flags_clear),
        .pending(pending), .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_busy(fpu_busy),
        .fpu_done(fpu_done), .fpu_result(fpu_result)
    );

    typedef struct { logic [31:0] op; logic [TW-1:0] tag; } item_t;
    item_t exp_q[$];
    item_t mon_e;

    int checks = 0;
    int failures = 0;
    int fixed_lat = 2;
    int abort_gen = 0;
    int model_seen = 0;
    int model_cnt = 0;
    logic [31:0] model_a = 32'd0;

    // Stand-in FPU result: known sqrt values for the directed operands, a fixed scramble otherwise.
    function automatic logic [31:0] model_sqrt(input logic [31:0] a);
        case (a)
            32'h4080_0000: return 32'h4000_0000;
            32'hBF80_0000: return 32'hFFC0_0000;
            32'h0000_0001: return 32'h0000_0000;
            32'h7F80_0001: return 32'h7FC0_0001;
            default:       return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    // Expected {invalid, nan_in, denorm_flushed} by operand class.
    function automatic logic [2:0] ref_flags(input logic [31:0] a);
        if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a[22] ? 3'b010 : 3'b110;
        if (a[30:0] == 31'd0) return 3'b000;
        return {a[31], 1'b0, (a[30:23] == 8'd0)};
    endfunction

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [22:0] f;
        logic [7:0]  e;
        s = 1'($urandom);
        f = 23'($urandom);
        e = 8'($urandom_range(1, 254));
        case ($urandom_range(0, 8))
            0:       return {1'b0, e, f};
            1:       return {1'b1, e, f};
            2:       return 32'h0000_0000;
            3:       return 32'h8000_0000;
            4:       return {s, 8'h00, f | 23'd1};
            5:       return {s, 8'hFF, 1'b1, f[21:0]};
            6:       return {s, 8'hFF, 1'b0, f[21:0] | 22'd1};
            7:       return {s, 8'hFF, 23'd0};
            default: return $urandom;
        endcase
    endfunction

    // Behavioural FPU: busy for a latency after start, result from the operand at done time.
    initial begin
        model_busy = 1'b0;
        model_done = 1'b0;
        fpu_result = 32'd0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (model_seen != abort_gen) begin
                model_seen = abort_gen;
                model_cnt  = 0;
                model_busy = 1'b0;
            end else if (model_cnt > 0) begin
                model_cnt = model_cnt - 1;
                if (model_cnt == 0) begin
                    model_done = 1'b1;
                    model_busy = 1'b0;
                    fpu_result = model_sqrt(fpu_a);
                    checks++;
                    if (fpu_a !== model_a) begin
                        failures++;
                        $display("FAIL fpu_a_stable got=%h want=%h", fpu_a, model_a);
                    end
                end
            end else if (fpu_start === 1'b1) begin
                model_a    = fpu_a;
                model_busy = 1'b1;
                model_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
            end
        end
    end

    // Scoreboard: every output handshake must match the oldest accepted operand.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result got_tag=%0d got=%h want=none", out_tag, out_result);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_result !== model_sqrt(mon_e.op) || out_tag !== mon_e.tag ||
                    out_flags !== ref_flags(mon_e.op)) begin
                    failures++;
                    $display("FAIL result got=%h/%0d/%b want=%h/%0d/%b", out_result, out_tag, out_flags,
                             model_sqrt(mon_e.op), mon_e.tag, ref_flags(mon_e.op));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand until accepted; returns one step after the accepting edge.
    task automatic push_op(input logic [31:0] op, input logic [TW-1:0] tag);
        logic acc = 1'b0;
        in_valid = 1'b1; in_operand = op; in_tag = tag;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back('{op, tag});
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin failures++; $display("FAIL push_timeout got=not_accepted want=accepted"); end
    endtask

    task automatic wait_valid(input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (out_valid === 1'b1);
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL %s_valid_timeout got=0 want=1", name); end
    endtask

    task automatic count_to_start(output int found);
        found = -1;
        for (int k = 1; k <= 40 && found < 0; k++) begin
            @(negedge clk);
            if (fpu_start === 1'b1) found = k;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_operand = 32'd0; in_tag = '0; out_ready = 1'b0;
        flags_clear = 1'b0; hold_busy = 1'b0; stray_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || pending !== 3'd0) begin
            failures++; $display("FAIL reset_fifo got=%b/%0d want=1/0", in_ready, pending);
        end
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== 4'd0 || out_flags !== 3'b000) begin
            failures++; $display("FAIL reset_out got=%b/%h/%0d/%b want=0/0/0/000", out_valid, out_result, out_tag, out_flags);
        end
        checks++;
        if (sticky_flags !== 3'b000 || fpu_start !== 1'b0 || fpu_a !== 32'd0) begin
            failures++; $display("FAIL reset_fpu got=%b/%b/%h want=000/0/0", sticky_flags, fpu_start, fpu_a);
        end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int found;
        fixed_lat = 2; out_ready = 1'b1;
        push_op(32'h4080_0000, 4'd3);
        count_to_start(found);
        checks++;
        if (found != 2) begin failures++; $display("FAIL start_latency got=%0d want=2", found); end
        wait_valid("basic");
        checks++;
        if (out_result !== 32'h4000_0000 || out_tag !== 4'd3 || out_flags !== 3'b000) begin
            failures++; $display("FAIL basic_out got=%h/%0d/%b want=40000000/3/000", out_result, out_tag, out_flags);
        end
        tick();
    endtask

    task automatic test_flags();
        push_op(32'hBF80_0000, 4'd5);
        wait_valid("neg");
        checks++;
        if (out_result !== 32'hFFC0_0000 || out_flags !== 3'b100 || sticky_flags !== 3'b100) begin
            failures++; $display("FAIL neg_flags got=%h/%b/%b want=ffc00000/100/100", out_result, out_flags, sticky_flags);
        end
        tick(); flags_clear = 1'b1;
        tick(); flags_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (sticky_flags !== 3'b000) begin failures++; $display("FAIL sticky_clear got=%b want=000", sticky_flags); end
        tick();
        push_op(32'h0000_0001, 4'd6);
        wait_valid("denorm");
        checks++;
        if (out_result !== 32'd0 || out_flags !== 3'b001) begin
            failures++; $display("FAIL denorm got=%h/%b want=00000000/001", out_result, out_flags);
        end
        tick();
        push_op(32'h7F80_0001, 4'd7);
        wait_valid("snan");
        checks++;
        if (out_flags !== 3'b110 || sticky_flags !== 3'b111) begin
            failures++; $display("FAIL snan got=%b/%b want=110/111", out_flags, sticky_flags);
        end
        tick();
        // Clear coinciding with a capture keeps that capture's flags.
        push_op(32'hBF80_0000, 4'd8);
        for (int i = 0; i < 100 && fpu_done !== 1'b1; i++) begin @(negedge clk); #1; end
        flags_clear = 1'b1;
        tick(); flags_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (sticky_flags !== 3'b100 || out_valid !== 1'b1) begin
            failures++; $display("FAIL clear_capture got=%b/%b want=100/1", sticky_flags, out_valid);
        end
        tick();
    endtask

    task automatic test_fill();
        out_ready = 1'b0; fixed_lat = 2;
        for (int t = 0; t < 5; t++) push_op(rand_op(), 4'(t));
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || pending !== 3'd4) begin
            failures++; $display("FAIL fill got=%b/%0d want=0/4", in_ready, pending);
        end
        wait_valid("fill");
        checks++;
        if (out_tag !== 4'd0) begin failures++; $display("FAIL fill_head got=%0d want=0", out_tag); end
    endtask

    task automatic test_full_pop();
        logic [31:0] op5;
        op5 = rand_op();
        tick();
        in_valid = 1'b1; in_operand = op5; in_tag = 4'd5; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL fullpop_h got=%b/%b want=1/0", out_valid, in_ready);
        end
        tick(); out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || pending !== 3'd4) begin
            failures++; $display("FAIL fullpop_reject got=%b/%0d want=0/4", in_ready, pending);
        end
        tick();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || pending !== 3'd3) begin
            failures++; $display("FAIL fullpop_accept got=%b/%0d want=1/3", in_ready, pending);
        end
        if (in_ready === 1'b1) exp_q.push_back('{op5, 4'd5});
        tick(); in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || pending !== 3'd4) begin
            failures++; $display("FAIL fullpop_after got=%b/%0d want=0/4", in_ready, pending);
        end
    endtask

    task automatic test_drain();
        tick(); out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_valid("drain");
            checks++;
            if (pending !== 3'(4 - k)) begin
                failures++; $display("FAIL drain_pending got=%0d want=%0d", pending, 4 - k);
            end
        end
        tick();
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL drain_left got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int found;
        fixed_lat = 1; out_ready = 1'b1;
        push_op(rand_op(), 4'd10);
        push_op(rand_op(), 4'd11);
        wait_valid("b2b");
        count_to_start(found);
        checks++;
        if (found != 2) begin failures++; $display("FAIL b2b_start got=%0d want=2", found); end
        wait_valid("b2b2");
        tick();
    endtask

    task automatic test_reset_mid();
        int found;
        logic bad;
        fixed_lat = 20; out_ready = 1'b1;
        for (int t = 0; t < 3; t++) push_op(rand_op(), 4'(12 + t));
        repeat (4) @(negedge clk);
        checks++;
        if (pending !== 3'd2 || out_valid !== 1'b0) begin
            failures++; $display("FAIL mid_pre got=%0d/%b want=2/0", pending, out_valid);
        end
        tick();
        reset = 1'b0; abort_gen++; exp_q.delete();
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || pending !== 3'd0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset got=%b/%0d/%b want=0/0/1", out_valid, pending, in_ready);
        end
        tick(); stray_done = 1'b1;
        tick(); stray_done = 1'b0;
        bad = 1'b0;
        repeat (4) begin @(negedge clk); if (out_valid !== 1'b0 || fpu_start !== 1'b0) bad = 1'b1; end
        checks++;
        if (bad) begin failures++; $display("FAIL stray_done got=output want=none"); end
        tick();
        fixed_lat = 3; hold_busy = 1'b1;
        push_op(32'h4080_0000, 4'd9);
        bad = 1'b0;
        repeat (6) begin @(negedge clk); if (fpu_start !== 1'b0) bad = 1'b1; end
        checks++;
        if (bad || pending !== 3'd1) begin
            failures++; $display("FAIL busy_hold got=%b/%0d want=0/1", bad, pending);
        end
        tick(); hold_busy = 1'b0;
        count_to_start(found);
        checks++;
        if (found != 2) begin failures++; $display("FAIL busy_release got=%0d want=2", found); end
        wait_valid("post_reset");
        tick();
    endtask

    task automatic test_random();
        int sent = 0;
        logic acc;
        logic fin = 1'b0;
        logic [2:0] sticky_exp = 3'b000;
        fixed_lat = 0;
        flags_clear = 1'b1; tick(); flags_clear = 1'b0;
        for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
            if (!in_valid && sent < 40 && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1; in_operand = rand_op(); in_tag = 4'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = (in_valid === 1'b1 && in_ready === 1'b1);
            if (acc) begin
                exp_q.push_back('{in_operand, in_tag});
                sticky_exp = sticky_exp | ref_flags(in_operand);
                sent++;
            end
            fin = (sent == 40 && exp_q.size() == 0);
            tick();
            if (acc) in_valid = 1'b0;
        end
        checks++;
        if (!fin) begin failures++; $display("FAIL random_timeout got=%0d_left want=0", exp_q.size()); end
        checks++;
        if (sticky_flags !== sticky_exp) begin
            failures++; $display("FAIL random_sticky got=%b want=%b", sticky_flags, sticky_exp);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_fill();
        test_full_pop();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
